// File: rtl/bit_serial_alu_seq.sv
// Sequencer that runs a WIDTH-bit operation through a 1-bit ALU slice, LSB first.
// Define BSALU_OVF_EN to add the signed-overflow output ovf.
module bit_serial_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       aluop,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_carryin,
    output logic [3:0]       slice_aluop,
    input  logic             slice_result,
    input  logic             slice_carryout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             err
`ifdef BSALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
`ifdef BSALU_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             is_add;
    logic             last_bit;
    logic [WIDTH-1:0] res_final;
    logic             in_run;

    assign in_run    = (state_q == S_RUN);
    assign is_add    = (op_q[1:0] == 2'b10);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    // Result bits collect in a WIDTH-1 shifter; the last bit joins only when the result is committed.
    assign res_final = {slice_result, res_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        result_d = result_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cout_d   = cout_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef BSALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (aluop[1:0] == 2'b11) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                        cout_d   = 1'b0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
`ifdef BSALU_OVF_EN
                        ovf_d    = 1'b0;
`endif
                    end else begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        a_sr_d   = op_a;
                        b_sr_d   = op_b;
                        op_d     = aluop;
                        carry_d  = aluop[2];
                        cnt_d    = '0;
                        res_sr_d = '0;
                    end
                end
            end
            S_RUN: begin
                res_sr_d = res_final[WIDTH-1:1];
                carry_d  = slice_carryout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                busy_d   = ~last_bit;
                if (last_bit) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = res_final;
                    cout_d   = is_add & slice_carryout;
                    zero_d   = (res_final == '0);
                    err_d    = 1'b0;
`ifdef BSALU_OVF_EN
                    // carry_q is the carry into the MSB on the final slice cycle
                    ovf_d    = is_add & (carry_q ^ slice_carryout);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
`ifdef BSALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            result_q <= result_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
`ifdef BSALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign slice_a       = in_run & a_sr_q[0];
    assign slice_b       = in_run & b_sr_q[0];
    assign slice_carryin = in_run & carry_q;
    assign slice_aluop   = in_run ? op_q : 4'b0000;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;
    assign err       = err_q;
`ifdef BSALU_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq: 1-bit slice model, arithmetic reference model, per-cycle compare.
// Checks ovf when BSALU_OVF_EN is defined.
module tb_bit_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   aluop;
    logic         slice_a, slice_b, slice_carryin;
    logic [3:0]   slice_aluop;
    logic         slice_result, slice_carryout;
    logic         busy, done, carry_out, zero, err;
    logic [W-1:0] result;
`ifdef BSALU_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bit_serial_alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .op_a(op_a), .op_b(op_b), .aluop(aluop),
        .slice_a(slice_a), .slice_b(slice_b), .slice_carryin(slice_carryin),
        .slice_aluop(slice_aluop), .slice_result(slice_result),
        .slice_carryout(slice_carryout),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .zero(zero), .err(err)
`ifdef BSALU_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // 1-bit ALU slice
    always_comb begin
        logic ea, eb;
        ea = slice_a ^ slice_aluop[3];
        eb = slice_b ^ slice_aluop[2];
        slice_result   = 1'b0;
        slice_carryout = 1'b0;
        case (slice_aluop[1:0])
            2'b00: slice_result = ea & eb;
            2'b01: slice_result = ea | eb;
            2'b10: begin
                slice_result   = ea ^ eb ^ slice_carryin;
                slice_carryout = (ea & eb) | (ea & slice_carryin) | (eb & slice_carryin);
            end
            default: slice_result = 1'b0;
        endcase
    end

    function automatic logic [W:0] f_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
        logic [W-1:0] ea, eb;
        ea = op[3] ? ~a : a;
        eb = op[2] ? ~b : b;
        return {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, op[2]};
    endfunction

    function automatic logic [W-1:0] f_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
        logic [W-1:0] ea, eb;
        logic [W:0]   s;
        ea = op[3] ? ~a : a;
        eb = op[2] ? ~b : b;
        s  = f_sum(a, b, op);
        case (op[1:0])
            2'b00:   return ea & eb;
            2'b01:   return ea | eb;
            2'b10:   return s[W-1:0];
            default: return '0;
        endcase
    endfunction

    function automatic logic f_cout(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] op);
        logic [W:0] s;
        s = f_sum(a, b, op);
        return (op[1:0] == 2'b10) ? s[W] : 1'b0;
    endfunction

    function automatic logic f_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op);
        logic [W-1:0] ea, eb;
        logic [W:0]   s;
        ea = op[3] ? ~a : a;
        eb = op[2] ? ~b : b;
        s  = f_sum(a, b, op);
        if (op[1:0] != 2'b10) return 1'b0;
        return (ea[W-1] == eb[W-1]) && (s[W-1] != ea[W-1]);
    endfunction

    // carry entering bit i of the operation
    function automatic logic f_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op, input int i);
        logic [W-1:0] ea, eb;
        logic [W:0]   mask, lo;
        if (op[1:0] != 2'b10) return (i == 0) ? op[2] : 1'b0;
        ea   = op[3] ? ~a : a;
        eb   = op[2] ? ~b : b;
        mask = (W+1)'((64'd1 << i) - 64'd1);
        lo   = ({1'b0, ea} & mask) + ({1'b0, eb} & mask) + {{W{1'b0}}, op[2]};
        return lo[i];
    endfunction

    // Reference model: transaction-level view of the sequencer
    logic         act = 1'b0;
    int           n = 0;
    int           len = 0;
    logic [W-1:0] ma = '0, mb = '0;
    logic [3:0]   mop = '0;
    logic [W-1:0] p_res = '0, m_res = '0;
    logic         p_cout = 1'b0, p_zero = 1'b1, p_err = 1'b0, p_ovf = 1'b0;
    logic         m_cout = 1'b0, m_zero = 1'b1, m_err = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            act    <= 1'b0;
            n      <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_zero <= 1'b1;
            m_err  <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (!act) begin
            if (start) begin
                act    <= 1'b1;
                n      <= 1;
                ma     <= op_a;
                mb     <= op_b;
                mop    <= aluop;
                len    <= (aluop[1:0] == 2'b11) ? 1 : W + 1;
                p_res  <= f_res(op_a, op_b, aluop);
                p_cout <= f_cout(op_a, op_b, aluop);
                p_zero <= (f_res(op_a, op_b, aluop) == '0);
                p_err  <= (aluop[1:0] == 2'b11);
                p_ovf  <= f_ovf(op_a, op_b, aluop);
            end
        end else if (n == len) begin
            act    <= 1'b0;
            n      <= 0;
            m_res  <= p_res;
            m_cout <= p_cout;
            m_zero <= p_zero;
            m_err  <= p_err;
            m_ovf  <= p_ovf;
        end else begin
            n <= n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (act && len > 1 && n <= W) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_done", 32'(done), 32'd0);
                check("run_slice_a", 32'(slice_a), 32'(ma[n-1]));
                check("run_slice_b", 32'(slice_b), 32'(mb[n-1]));
                check("run_slice_cin", 32'(slice_carryin), 32'(f_cin(ma, mb, mop, n - 1)));
                check("run_slice_op", 32'(slice_aluop), 32'(mop));
            end else begin
                check("slice_a_idle", 32'(slice_a), 32'd0);
                check("slice_b_idle", 32'(slice_b), 32'd0);
                check("slice_cin_idle", 32'(slice_carryin), 32'd0);
                check("slice_op_idle", 32'(slice_aluop), 32'd0);
                check("busy_idle", 32'(busy), 32'd0);
                if (act && n == len) begin
                    check("done_pulse", 32'(done), 32'd1);
                    check("done_result", 32'(result), 32'(p_res));
                    check("done_cout", 32'(carry_out), 32'(p_cout));
                    check("done_zero", 32'(zero), 32'(p_zero));
                    check("done_err", 32'(err), 32'(p_err));
`ifdef BSALU_OVF_EN
                    check("done_ovf", 32'(ovf), 32'(p_ovf));
`endif
                end else begin
                    check("idle_done", 32'(done), 32'd0);
                    check("idle_result", 32'(result), 32'(m_res));
                    check("idle_cout", 32'(carry_out), 32'(m_cout));
                    check("idle_zero", 32'(zero), 32'(m_zero));
                    check("idle_err", 32'(err), 32'(m_err));
`ifdef BSALU_OVF_EN
                    check("idle_ovf", 32'(ovf), 32'(m_ovf));
`endif
                end
            end
        end
    end

    // Waits (bounded) for done; returns cycles counted from the accept edge.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        if (!done) lat = 99;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input int exp_lat, input logic [W-1:0] lit_res,
                          input logic lit_cout, input logic lit_zero, input logic lit_err);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; aluop = op;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_res"}, 32'(result), 32'(lit_res));
        check({name, "_model_res"}, 32'(p_res), 32'(lit_res));
        check({name, "_cout"}, 32'(carry_out), 32'(lit_cout));
        check({name, "_zero"}, 32'(zero), 32'(lit_zero));
        check({name, "_err"}, 32'(err), 32'(lit_err));
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; aluop = '0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);

        run_op("add", 8'h05, 8'h03, 4'b0010, 9, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg", 8'h05, 8'h07, 4'b0110, 9, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_zero", 8'h07, 8'h07, 4'b0110, 9, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("and", 8'hF0, 8'h3C, 4'b0000, 9, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("or", 8'hF0, 8'h3C, 4'b0001, 9, 8'hFC, 1'b0, 1'b0, 1'b0);
        run_op("nor", 8'hF0, 8'h3C, 4'b1100, 9, 8'h03, 1'b0, 1'b0, 1'b0);
        run_op("illegal", 8'hAA, 8'h55, 4'b0011, 1, 8'h00, 1'b0, 1'b1, 1'b1);
        run_op("add_wrap", 8'hFF, 8'h01, 4'b0010, 9, 8'h00, 1'b1, 1'b1, 1'b0);

        // start during RUN must be ignored
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'h05; op_b = 8'h03; aluop = 4'b0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #1;
        start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; aluop = 4'b0011;
        repeat (3) @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("ign_done", 32'(done), 32'd1);
        check("ign_res", 32'(result), 32'h08);
        check("ign_err", 32'(err), 32'd0);

        // reset in RUN cycle 4 aborts without a done pulse
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'h05; op_b = 8'h03; aluop = 4'b0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        run_op("after_rst", 8'h05, 8'h03, 4'b0010, 9, 8'h08, 1'b0, 1'b0, 1'b0);

        run_op("ovf_add", 8'h7F, 8'h01, 4'b0010, 9, 8'h80, 1'b0, 1'b0, 1'b0);
`ifdef BSALU_OVF_EN
        check("ovf_add_ovf", 32'(ovf), 32'd1);
`endif
        check("ovf_add_model", 32'(p_ovf), 32'd1);
        run_op("ovf_sub", 8'h80, 8'h01, 4'b0110, 9, 8'h7F, 1'b1, 1'b0, 1'b0);
`ifdef BSALU_OVF_EN
        check("ovf_sub_ovf", 32'(ovf), 32'd1);
`endif
        check("ovf_sub_model", 32'(p_ovf), 32'd1);
        run_op("no_ovf", 8'h01, 8'h01, 4'b0010, 9, 8'h02, 1'b0, 1'b0, 1'b0);
`ifdef BSALU_OVF_EN
        check("no_ovf_ovf", 32'(ovf), 32'd0);
`endif
        check("no_ovf_model", 32'(p_ovf), 32'd0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Sequencer that drives a 1-bit ALU slice (ports a, b, carryin, ALUop[3:0] -> result, carryout) once per clock, LSB first, to run a full WIDTH-bit operation.
- Sits between the register/operand stage and the slice: it feeds the slice and consumes what the slice produces.
- Holds operands and the result in shift registers, carries the carry between cycles, and signals completion with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op_a  input  WIDTH  operand A; latched on an accepted start.
- op_b  input  WIDTH  operand B; latched on an accepted start.
- aluop  input  4  [3]=Ainvert, [2]=Bnegate, [1:0]: 00 AND, 01 OR, 10 ADD, 11 illegal.
- slice_a  output  1  current A bit sent to the slice.
- slice_b  output  1  current B bit sent to the slice.
- slice_carryin  output  1  current carry sent to the slice.
- slice_aluop  output  4  latched aluop sent to the slice.
- slice_result  input  1  result bit returned by the slice (combinational).
- slice_carryout  input  1  carry returned by the slice (combinational).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  assembled result; held until the next accepted start.
- carry_out  output  1  final carry of an ADD; 0 for AND/OR.
- zero  output  1  high when result == 0; valid from done onward.
- err  output  1  high when the latched op was illegal; held with result.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: IDLE. busy=0, done=0, result=0, carry_out=0, zero=1, err=0, counter=0, slice_* outputs=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on start=1 with aluop[1:0]!=11.
  - Latch op_a, op_b, aluop; counter=0.
  - Carry register is set to aluop[2], so Bnegate=1 yields A-B via two's complement.
- IDLE -> DONE: on start=1 with aluop[1:0]==11. result=0, carry_out=0, zero=1, err=1; no slice cycles are run.
- RUN, every cycle:
  - slice_a=A_sr[0], slice_b=B_sr[0], slice_carryin=carry_reg, slice_aluop=latched op (combinational from registers).
  - At the clock edge: shift slice_result into result_sr MSB with a right shift; carry_reg<=slice_carryout; A_sr and B_sr shift right; counter increments.
- RUN -> DONE: after the edge where counter==WIDTH-1, so RUN lasts exactly WIDTH cycles.
- DONE: one cycle. done=1; result, carry_out (=carry_reg if aluop[1:0]==10, else 0), zero and err are registered. Then DONE -> IDLE.
- Latency: done asserts WIDTH+1 cycles after the start-accept edge; 1 cycle for an illegal op.
- start while busy or in DONE is ignored; no queueing.
- Outside RUN, the slice_* outputs are driven to 0.
- The slice forces carryout=0 for AND/OR; the sequencer does not depend on that and masks carry_out itself.
- reset mid-RUN: abort on that edge, return to the reset state, no done pulse.
- Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.

Optional Feature:
- Macro: BSALU_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - For ADD, ovf = carry into the MSB XOR carry out of the MSB. The carry into the MSB is captured as carry_reg at counter==WIDTH-1.
  - ovf=0 for AND/OR/illegal ops; registered at DONE.
- Undefined: no ovf port and no extra register; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, aluop=0010, start -> done exactly 9 cycles later; result=0x08, carry_out=0, zero=0, err=0.
- a=0x05, b=0x07, aluop=0110 (SUB) -> result=0xFE, carry_out=0; then a=0x07, b=0x07 -> result=0x00, zero=1, carry_out=1.
- a=0xF0, b=0x3C, aluop=0000 -> 0x30; aluop=0001 -> 0xFC; aluop=1100 (NOR) -> 0x03; carry_out=0 in all three.
- aluop=0011 with start -> done the next cycle, err=1, result=0x00, slice_aluop stays 0; a second start during RUN of a valid op is ignored and result is unchanged.
- reset asserted at RUN cycle 4 -> next cycle busy=0, result=0, done never pulses; a fresh start then completes normally.
- With BSALU_OVF_EN: a=0x7F, b=0x01, ADD -> result=0x80, ovf=1; a=0x80, b=0x01, SUB -> result=0x7F, ovf=1; a=0x01, b=0x01, ADD -> ovf=0.
